// File: rtl/arb2_4.sv
// Two-source arbiter that steers a downstream mux2_4 and captures its result.
// Define ARB2_4_FIXED_PRIO_EN for fixed priority (A wins ties) instead of round-robin.
module arb2_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             s,
    input  logic [WIDTH-1:0] mux_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [7:0]       xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             s_nxt;
    logic             grant_b;
    logic             out_valid_nxt;
    logic [WIDTH-1:0] out_data_nxt;
    logic [7:0]       xfer_cnt_nxt;

`ifndef ARB2_4_FIXED_PRIO_EN
    // last_b = 1 when source B completed the most recent transfer
    logic last_b, last_b_nxt;
`endif

    // Source data reaches us only through the external mux; these ports are pass-through.
    logic unused_data;
    assign unused_data = ^{a_data, b_data};

    always_comb begin
        grant_b = b_valid & ~a_valid;
`ifndef ARB2_4_FIXED_PRIO_EN
        if (a_valid && b_valid) begin
            grant_b = ~last_b;
        end
`endif
    end

    always_comb begin
        state_nxt     = state;
        s_nxt         = s;
        out_valid_nxt = out_valid;
        out_data_nxt  = out_data;
        xfer_cnt_nxt  = xfer_cnt;
`ifndef ARB2_4_FIXED_PRIO_EN
        last_b_nxt    = last_b;
`endif
        case (state)
            IDLE: begin
                if (a_valid || b_valid) begin
                    s_nxt     = grant_b;
                    state_nxt = SEL;
                end
            end
            SEL: begin
                out_data_nxt  = mux_out;
                out_valid_nxt = 1'b1;
                state_nxt     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    xfer_cnt_nxt  = xfer_cnt + 8'd1;
`ifndef ARB2_4_FIXED_PRIO_EN
                    last_b_nxt    = s;
`endif
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s         <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            xfer_cnt  <= 8'd0;
`ifndef ARB2_4_FIXED_PRIO_EN
            last_b    <= 1'b1;
`endif
        end else begin
            state     <= state_nxt;
            s         <= s_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            xfer_cnt  <= xfer_cnt_nxt;
`ifndef ARB2_4_FIXED_PRIO_EN
            last_b    <= last_b_nxt;
`endif
        end
    end

    // Ready pulses last exactly the SEL cycle; s selects which source it belongs to.
    assign a_ready = (state == SEL) && !s;
    assign b_ready = (state == SEL) &&  s;

endmodule

// File: tb/tb_arb2_4.sv
// Directed-vector bench for arb2_4 with a behavioural mux2_4 on the return path.
module tb_arb2_4;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_valid, b_valid, out_ready;
    logic [WIDTH-1:0] a_data, b_data, mux_out, out_data;
    logic             a_ready, b_ready, s, out_valid;
    logic [7:0]       xfer_cnt;

    int errors = 0;
    int checks = 0;

    arb2_4 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .s        (s),
        .mux_out  (mux_out),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .xfer_cnt (xfer_cnt)
    );

    assign mux_out = s ? b_data : a_data;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    logic exp_s;
    int   pulses;

    initial begin
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
        a_data = '0; b_data = '0;

        // reset, then idle for 10 cycles
        do_reset();
        repeat (10) cyc();
        check("idle_out_valid", out_valid, 0);
        check("idle_s", s, 0);
        check("idle_a_ready", a_ready, 0);
        check("idle_b_ready", b_ready, 0);
        check("idle_xfer_cnt", xfer_cnt, 0);
        check("idle_out_data", out_data, 0);

        // out_ready with nothing valid is ignored
        out_ready = 1'b1;
        repeat (3) cyc();
        check("stray_ready_cnt", xfer_cnt, 0);

        // single A transfer with data 0000
        a_valid = 1'b1; a_data = 4'b0000; b_data = 4'b1111;
        cyc();
        check("a_sel_s", s, 0);
        check("a_sel_a_ready", a_ready, 1);
        check("a_sel_b_ready", b_ready, 0);
        check("a_sel_out_valid", out_valid, 0);
        a_valid = 1'b0;
        cyc();
        check("a_hold_out_valid", out_valid, 1);
        check("a_hold_out_data", out_data, 4'b0000);
        check("a_hold_a_ready", a_ready, 0);
        cyc();
        check("a_done_out_valid", out_valid, 0);
        check("a_done_cnt", xfer_cnt, 1);

        // single A transfer with a non-zero word
        a_valid = 1'b1; a_data = 4'b0110;
        cyc();
        a_valid = 1'b0;
        cyc();
        check("a2_out_data", out_data, 4'b0110);
        cyc();
        check("a2_cnt", xfer_cnt, 2);

        // both valid continuously: round-robin alternates, fixed priority sticks to A
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1; a_data = 4'b0000; b_data = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
`ifdef ARB2_4_FIXED_PRIO_EN
            exp_s = 1'b0;
`else
            exp_s = (i % 2 == 1);
`endif
            cyc();
            check("rr_s", s, exp_s);
            check("rr_a_ready", a_ready, !exp_s);
            check("rr_b_ready", b_ready, exp_s);
            cyc();
            check("rr_out_valid", out_valid, 1);
            check("rr_out_data", out_data, exp_s ? 4'b1111 : 4'b0000);
            cyc();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check("rr_cnt", xfer_cnt, 3);

        // B transfer with a stalled consumer
        do_reset();
        b_valid = 1'b1; b_data = 4'b1010; a_data = 4'b0101; out_ready = 1'b0;
        pulses = 0;
        cyc();
        check("b_sel_s", s, 1);
        check("b_sel_b_ready", b_ready, 1);
        check("b_sel_a_ready", a_ready, 0);
        if (b_ready) pulses++;
        b_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("b_hold_out_valid", out_valid, 1);
            check("b_hold_out_data", out_data, 4'b1010);
            if (b_ready) pulses++;
        end
        out_ready = 1'b1;
        cyc();
        if (b_ready) pulses++;
        check("b_done_out_valid", out_valid, 0);
        check("b_done_cnt", xfer_cnt, 1);
        check("b_ready_pulses", pulses, 1);

        // reset while holding a word
        do_reset();
        a_valid = 1'b1; a_data = 4'b0101; out_ready = 1'b0;
        cyc();
        a_valid = 1'b0;
        cyc();
        check("rh_out_valid_pre", out_valid, 1);
        rst = 1'b1; out_ready = 1'b1;
        cyc();
        check("rh_out_valid", out_valid, 0);
        check("rh_cnt", xfer_cnt, 0);
        check("rh_out_data", out_data, 0);
        check("rh_a_ready", a_ready, 0);
        rst = 1'b0;
        a_valid = 1'b1; a_data = 4'b0011;
        cyc();
        check("rh_idle_then_sel", a_ready, 1);
        a_valid = 1'b0;
        cyc();
        check("rh_next_data", out_data, 4'b0011);
        cyc();
        check("rh_next_cnt", xfer_cnt, 1);

        // 256 back-to-back A transfers wrap the counter
        do_reset();
        a_valid = 1'b1; a_data = 4'b1001; out_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 255 * 3; i++) begin
            cyc();
            if (a_ready) pulses++;
        end
        check("wrap_cnt_255", xfer_cnt, 255);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (a_ready) pulses++;
        end
        a_valid = 1'b0;
        check("wrap_cnt_0", xfer_cnt, 0);
        check("wrap_pulses", pulses, 256);
        cyc();
        check("wrap_idle_out_valid", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
